// File: rtl/sub_pkg.sv
// Shared types and helpers for the subtractor result stage.
package sub_pkg;

    localparam int unsigned SUB_WIDTH = 32;

    typedef struct packed {
        logic [SUB_WIDTH-1:0] f;
        logic                 ovf;
        logic                 zero;
        logic                 neg;
    } sub_res_t;

    // Ceiling log2; callers only pass n >= 2.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_result_fifo.sv
// DEPTH-entry valid/ready FIFO of sub_res_t with a registered, count-derived ready.
// SUB_RESULT_PARITY_EN adds a stored parity bit per entry.
module sub_result_fifo
    import sub_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  sub_res_t      wdata,
`ifdef SUB_RESULT_PARITY_EN
    input  logic          wpar,
    output logic          rpar,
`endif
    output sub_res_t      rdata,
    output logic          ready,
    output logic [CW-1:0] count
);

    sub_res_t      mem [DEPTH];
`ifdef SUB_RESULT_PARITY_EN
    logic          par_mem [DEPTH];
`endif
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_sel;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
`ifdef SUB_RESULT_PARITY_EN
                par_mem[i] <= 1'b0;
`endif
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
`ifdef SUB_RESULT_PARITY_EN
                par_mem[wr_ptr] <= wpar;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            ready <= (count_nxt < CW'(DEPTH));
        end
    end

    // When empty, show the slot just behind the read pointer: the last popped entry.
    assign rd_sel = (count != '0) ? rd_ptr : rd_ptr - PW'(1);
    assign rdata  = mem[rd_sel];
`ifdef SUB_RESULT_PARITY_EN
    assign rpar   = par_mem[rd_sel];
`endif

endmodule

// File: rtl/sub_result_stage.sv
// Registered stage after the subtractor: result FIFO, zero/neg flags, sticky overflow and counter.
// SUB_RESULT_PARITY_EN adds out_parity / parity_inj.
module sub_result_stage
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_f,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
`ifdef SUB_RESULT_PARITY_EN
    output logic             out_parity,
    input  logic             parity_inj,
`endif
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned CW = clog2(DEPTH) + 1;

    sub_res_t      wdata;
    sub_res_t      head;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Flags are fixed at push time and travel with the entry.
    always_comb begin
        wdata      = '0;
        wdata.f    = SUB_WIDTH'(in_f);
        wdata.ovf  = in_overflow;
        wdata.zero = (in_f == '0);
        wdata.neg  = in_f[WIDTH-1];
    end

    sub_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
`ifdef SUB_RESULT_PARITY_EN
        .wpar  ((^{in_f, in_overflow}) ^ parity_inj),
        .rpar  (out_parity),
`endif
        .rdata (head),
        .ready (in_ready),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_f     = WIDTH'(head.f);
    assign out_ovf   = head.ovf;
    assign out_zero  = head.zero;
    assign out_neg   = head.neg;

    // An overflow push in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (push && in_overflow) begin
            sticky_ovf <= 1'b1;
            if (sticky_clr) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule
